ps2_note_sequencer: RTL and testbench

PS2_NOTE_SEQUENCER -- requirements
Module: ps2_note_sequencer

---
 rtl/ps2_note_pkg.sv | 48 ++++
 rtl/note_event_fifo.sv | 65 ++++++
 rtl/ps2_note_sequencer.sv | 98 +++++++++
 tb/tb_ps2_note_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_note_pkg.sv
// Shared PS/2 note sequencer types: parser states, prefix and ignore
// byte constants, the event payload, and the scan-code-to-note table.
package ps2_note_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_NONE  = 8'h00;

    typedef struct packed {
        logic [3:0] note;
        logic       press;
    } note_evt_t;

    function automatic logic is_ignored(input logic [7:0] code);
        return code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};
    endfunction

    // Returns {hit, note}; hit is 0 for every unmapped code.
    function automatic logic [4:0] map_note(input logic [7:0] code);
        logic [4:0] r;
        r = 5'b0;
        case (code)
            8'h1C: r = {1'b1, 4'd0};
            8'h1D: r = {1'b1, 4'd1};
            8'h1B: r = {1'b1, 4'd2};
            8'h24: r = {1'b1, 4'd3};
            8'h23: r = {1'b1, 4'd4};
            8'h2B: r = {1'b1, 4'd5};
            8'h2C: r = {1'b1, 4'd6};
            8'h34: r = {1'b1, 4'd7};
            8'h35: r = {1'b1, 4'd8};
            8'h33: r = {1'b1, 4'd9};
            8'h3C: r = {1'b1, 4'd10};
            8'h3B: r = {1'b1, 4'd11};
            8'h42: r = {1'b1, 4'd12};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/note_event_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag;
// a push into a full FIFO is still accepted when a pop happens together.
module note_event_fifo
    import ps2_note_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  note_evt_t push_data,
    input  logic      pop,
    output note_evt_t head,
    output logic      valid,
    output logic      overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    note_evt_t     mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign valid   = (count != '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW + 1)'(1);
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_note_sequencer.sv
// PS/2 scan-code parser driving a monophonic last-note-priority keyboard;
// note-on/off events are queued for a downstream synth voice.
module ps2_note_sequencer
    import ps2_note_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [3:0] evt_note,
    output logic       evt_press,
    output logic [7:0] held_code,
    output logic       gate,
    output logic       overflow,
    output logic [1:0] state_dbg
);

    ps2_state_t state;
    logic [4:0] lookup;
    logic       hit;
    logic       strobe;
    logic       make_hit;
    logic       brk_hit;
    note_evt_t  push_evt;
    note_evt_t  head;

    assign lookup = map_note(received_data);
    assign hit    = lookup[4];
    assign strobe = received_data_en && !reset;

    // Prefix and ignore bytes never hit the table, so hit alone qualifies a make.
    assign make_hit = strobe && (state == ST_IDLE) && hit
                      && (received_data != held_code);
    assign brk_hit  = strobe && (state == ST_BRK) && hit
                      && (received_data == held_code);

    assign push_evt.note  = lookup[3:0];
    assign push_evt.press = make_hit;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= ST_IDLE;
            held_code <= CODE_NONE;
            gate      <= 1'b0;
        end else if (received_data_en) begin
            unique case (state)
                ST_IDLE: begin
                    if (received_data == CODE_BREAK) begin
                        state <= ST_BRK;
                    end else if (received_data == CODE_EXT) begin
                        state <= ST_EXT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (received_data == CODE_BREAK) begin
                        state <= ST_EXT_BRK;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (make_hit) begin
                held_code <= received_data;
                gate      <= 1'b1;
            end else if (brk_hit) begin
                held_code <= CODE_NONE;
                gate      <= 1'b0;
            end
        end
    end

    assign state_dbg = state;

    note_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .reset    (reset),
        .push     (make_hit || brk_hit),
        .push_data(push_evt),
        .pop      (evt_ready),
        .head     (head),
        .valid    (evt_valid),
        .overflow (overflow)
    );

    assign evt_note  = head.note;
    assign evt_press = head.press;

endmodule

// File: tb/tb_ps2_note_sequencer.sv
// Scoreboard bench: a prefix-queue keyboard model predicts events and
// status; a negedge monitor pops and compares whenever an event leaves.
module tb_ps2_note_sequencer;

    localparam int DEPTH = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_note;
    logic       evt_press;
    logic [7:0] held_code;
    logic       gate;
    logic       overflow;
    logic [1:0] state_dbg;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_note_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_note        (evt_note),
        .evt_press       (evt_press),
        .held_code       (held_code),
        .gate            (gate),
        .overflow        (overflow),
        .state_dbg       (state_dbg)
    );

    logic [7:0] keys [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                              8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B,
                              8'h42};
    logic [7:0] misc [7] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h75,
                             8'h15};

    int n_chk  = 0;
    int n_pass = 0;

    logic [4:0] sb [$];
    logic [7:0] pre [$];
    logic [7:0] m_held = 8'h00;
    logic       pend_v = 1'b0;
    logic [4:0] pend_ev = 5'd0;
    logic       rst_pend = 1'b0;
    logic [7:0] nxt_held = 8'h00;
    logic [1:0] nxt_st = 2'd0;
    logic [7:0] cur_held = 8'h00;
    logic [1:0] cur_st = 2'd0;
    logic       cur_ovf = 1'b0;
    logic       after_rst = 1'b0;
    logic       checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int note_of(input logic [7:0] b);
        for (int i = 0; i < 13; i++) begin
            if (keys[i] == b) return i;
        end
        return -1;
    endfunction

    function automatic logic [1:0] pre_state();
        if (pre.size() == 0) return 2'd0;
        if (pre[0] == 8'hF0) return 2'd1;
        if (pre.size() == 1) return 2'd2;
        return 2'd3;
    endfunction

    // A key code completes once its prefix bytes have been collected.
    task automatic model(input logic [7:0] b);
        int n;
        n = note_of(b);
        if (pre.size() == 0 && (b == 8'hF0 || b == 8'hE0)) begin
            pre.push_back(b);
        end else if (pre.size() == 1 && pre[0] == 8'hE0 && b == 8'hF0) begin
            pre.push_back(b);
        end else begin
            if (pre.size() == 0) begin
                if (n >= 0 && b != m_held) begin
                    m_held  = b;
                    pend_v  = 1'b1;
                    pend_ev = {4'(n), 1'b1};
                end
            end else if (pre.size() == 1 && pre[0] == 8'hF0) begin
                if (n >= 0 && b == m_held) begin
                    m_held  = 8'h00;
                    pend_v  = 1'b1;
                    pend_ev = {4'(n), 1'b0};
                end
            end
            pre.delete();
        end
    endtask

    task automatic commit();
        if (rst_pend) begin
            sb.delete();
            cur_ovf   = 1'b0;
            after_rst = 1'b1;
            rst_pend  = 1'b0;
        end else if (pend_v) begin
            if (sb.size() < DEPTH) sb.push_back(pend_ev);
            else cur_ovf = 1'b1;
        end
        pend_v   = 1'b0;
        cur_held = nxt_held;
        cur_st   = nxt_st;
    endtask

    task automatic send(input logic [7:0] b, input logic en,
                        input logic rdy);
        @(posedge CLOCK_50);
        #1;
        commit();
        reset            = 1'b0;
        received_data    = b;
        received_data_en = en;
        evt_ready        = rdy;
        if (en) model(b);
        nxt_held = m_held;
        nxt_st   = pre_state();
    endtask

    task automatic do_reset(input logic [7:0] b);
        @(posedge CLOCK_50);
        #1;
        commit();
        reset            = 1'b1;
        received_data    = b;
        received_data_en = 1'b1;
        evt_ready        = 1'b0;
        rst_pend = 1'b1;
        m_held   = 8'h00;
        pre.delete();
        nxt_held = 8'h00;
        nxt_st   = 2'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'h00, 1'b0, 1'b1);
    endtask

    always @(negedge CLOCK_50) begin
        if (checking) begin
            logic [4:0] h;
            chk("evt_valid", 32'(evt_valid), 32'(sb.size() != 0));
            if (evt_valid && sb.size() > 0) begin
                h = sb[0];
                chk("evt_note", 32'(evt_note), 32'(h[4:1]));
                chk("evt_press", 32'(evt_press), 32'(h[0]));
                if (evt_ready) void'(sb.pop_front());
            end else if (after_rst) begin
                chk("rst_note", 32'(evt_note), 32'd0);
                chk("rst_press", 32'(evt_press), 32'd0);
            end
            after_rst = 1'b0;
            chk("held_code", 32'(held_code), 32'(cur_held));
            chk("gate", 32'(gate), 32'(cur_held != 8'h00));
            chk("state_dbg", 32'(state_dbg), 32'(cur_st));
            chk("overflow", 32'(overflow), 32'(cur_ovf));
        end
    end

    initial begin
        logic [7:0] b;
        logic       rdy_mode;
        reset            = 1'b1;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        evt_ready        = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        do_reset(8'h1C);
        checking = 1'b1;

        send(8'h1C, 1, 1); send(8'h00, 0, 1);
        send(8'hF0, 1, 1); send(8'h1C, 1, 1); idle(3);

        send(8'h1C, 1, 1); send(8'h1C, 1, 1); send(8'h1C, 1, 1);
        send(8'hF0, 1, 1); send(8'h1C, 1, 1); idle(3);

        send(8'h1C, 1, 1); send(8'h23, 1, 1);
        send(8'hF0, 1, 1); send(8'h1C, 1, 1);
        send(8'hF0, 1, 1); send(8'h23, 1, 1); idle(3);

        send(8'hE0, 1, 1); send(8'h75, 1, 1);
        send(8'hE0, 1, 1); send(8'hF0, 1, 1); send(8'h75, 1, 1);
        send(8'h15, 1, 1); send(8'hF0, 1, 1); send(8'h15, 1, 1); idle(2);

        send(8'h1C, 1, 0); send(8'h1D, 1, 0); send(8'h1B, 1, 0);
        send(8'h24, 1, 0); send(8'h23, 1, 0); send(8'h00, 0, 0);
        idle(DEPTH + 2);
        send(8'hF0, 1, 1); send(8'h23, 1, 1); idle(2);

        send(8'h1C, 1, 1); send(8'hF0, 1, 1);
        do_reset(8'h1C);
        send(8'h1C, 1, 1); idle(3);

        rdy_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) rdy_mode = ~rdy_mode;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = keys[$urandom_range(0, 12)];
                4, 5:       b = 8'hF0;
                6:          b = 8'hE0;
                7:          b = misc[$urandom_range(0, 6)];
                default:    b = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                do_reset(b);
            end else begin
                send(b, ($urandom_range(0, 2) != 0),
                     rdy_mode ? 1'b1 : ($urandom_range(0, 3) == 0));
            end
        end

        idle(DEPTH + 3);
        chk("drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
